// File: rtl/shift_unit_sequencer.sv
// Round-robin front end that shares one combinational 32-bit shifter between two requesters.
// Clamps out-of-range amounts, runs rotates as two passes and returns a registered, tagged result.
module shift_unit_sequencer #(
    parameter int FIRST_GRANT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_data,
    input  logic [31:0] req0_amt,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_data,
    input  logic [31:0] req1_amt,
    input  logic [2:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_id,
    output logic [31:0] sh_in,
    output logic [31:0] sh_amt,
    output logic        sh_left,
    output logic        sh_arith,
    input  logic [31:0] sh_out,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, PASS1 = 2'd1, PASS2 = 2'd2, DONE = 2'd3} state_t;

    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;
    // lastGrant_r holds the previous winner, so resetting it to the other requester favours FIRST_GRANT.
    localparam logic RR_RESET = (FIRST_GRANT == 0) ? 1'b1 : 1'b0;

    state_t      state_r;
    logic        lastGrant_r;
    logic [31:0] data_r;
    logic [2:0]  op_r;
    logic        big_r;
    logic [4:0]  n_r;
    logic [31:0] acc_r;
    logic        id_r;
    logic        rspValid_r;
    logic        busy_r;
    logic [31:0] shIn_r;
    logic [31:0] shAmt_r;
    logic        shLeft_r;
    logic        shArith_r;

    logic        grant0_s;
    logic        grant1_s;
    logic        handshake_s;
    logic [31:0] selData_s;
    logic [31:0] selAmt_s;
    logic [2:0]  selOp_s;
    logic        selBig_s;
    logic [4:0]  selN_s;
    logic [31:0] p1Amt_s;
    logic        p1Left_s;
    logic        p1Arith_s;
    logic [5:0]  rotBack_s;
    logic        isRotate_s;

    // Arbiter: a lone valid requester wins, otherwise alternate against the previous winner.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (state_r == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0_s = lastGrant_r;
                grant1_s = !lastGrant_r;
            end else begin
                grant0_s = req0_valid;
                grant1_s = req1_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign req0_ready  = grant0_s;
    assign req1_ready  = grant1_s;
    assign handshake_s = grant0_s | grant1_s;
    assign selData_s   = grant1_s ? req1_data : req0_data;
    assign selAmt_s    = grant1_s ? req1_amt : req0_amt;
    assign selOp_s     = grant1_s ? req1_op : req0_op;
    assign selBig_s    = |selAmt_s[31:5];
    assign selN_s      = selAmt_s[4:0];
    assign rotBack_s   = 6'd32 - {1'b0, n_r};
    assign isRotate_s  = (op_r == OP_ROL) || (op_r == OP_ROR);

    // First-pass shifter controls derived from the request being accepted.
    always_comb begin
        p1Amt_s   = 32'd0;
        p1Left_s  = 1'b0;
        p1Arith_s = 1'b0;
        case (selOp_s)
            OP_SLL: begin
                p1Left_s = 1'b1;
                p1Amt_s  = selBig_s ? 32'd0 : {27'd0, selN_s};
            end
            OP_SRL: p1Amt_s = selBig_s ? 32'd0 : {27'd0, selN_s};
            OP_SRA: begin
                p1Arith_s = 1'b1;
                p1Amt_s   = selBig_s ? 32'd31 : {27'd0, selN_s};
            end
            OP_ROL: begin
                p1Left_s = 1'b1;
                p1Amt_s  = {27'd0, selN_s};
            end
            OP_ROR: p1Amt_s = {27'd0, selN_s};
            default: begin
                p1Amt_s   = 32'd0;
                p1Left_s  = 1'b0;
                p1Arith_s = 1'b0;
            end
        endcase
    end

    // Sequencer: shifter controls are registered one state ahead so they are stable for the whole pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            lastGrant_r <= RR_RESET;
            data_r      <= 32'd0;
            op_r        <= 3'd0;
            big_r       <= 1'b0;
            n_r         <= 5'd0;
            acc_r       <= 32'd0;
            id_r        <= 1'b0;
            rspValid_r  <= 1'b0;
            busy_r      <= 1'b0;
            shIn_r      <= 32'd0;
            shAmt_r     <= 32'd0;
            shLeft_r    <= 1'b0;
            shArith_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (handshake_s) begin
                        data_r      <= selData_s;
                        op_r        <= selOp_s;
                        big_r       <= selBig_s;
                        n_r         <= selN_s;
                        id_r        <= grant1_s;
                        lastGrant_r <= grant1_s;
                        shIn_r      <= selData_s;
                        shAmt_r     <= p1Amt_s;
                        shLeft_r    <= p1Left_s;
                        shArith_r   <= p1Arith_s;
                        busy_r      <= 1'b1;
                        state_r     <= PASS1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                PASS1: begin
                    if (op_r > OP_ROR) begin
                        acc_r <= data_r;
                    end else if (big_r && ((op_r == OP_SLL) || (op_r == OP_SRL))) begin
                        acc_r <= 32'd0;
                    end else begin
                        acc_r <= sh_out;
                    end
                    if (isRotate_s && (n_r != 5'd0)) begin
                        shIn_r    <= data_r;
                        shAmt_r   <= {26'd0, rotBack_s};
                        shLeft_r  <= (op_r == OP_ROR);
                        shArith_r <= 1'b0;
                        state_r   <= PASS2;
                    end else begin
                        shIn_r     <= 32'd0;
                        shAmt_r    <= 32'd0;
                        shLeft_r   <= 1'b0;
                        shArith_r  <= 1'b0;
                        rspValid_r <= 1'b1;
                        state_r    <= DONE;
                    end
                end
                PASS2: begin
                    acc_r      <= acc_r | sh_out;
                    shIn_r     <= 32'd0;
                    shAmt_r    <= 32'd0;
                    shLeft_r   <= 1'b0;
                    shArith_r  <= 1'b0;
                    rspValid_r <= 1'b1;
                    state_r    <= DONE;
                end
                DONE: begin
                    if (rsp_ready) begin
                        rspValid_r <= 1'b0;
                        busy_r     <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    rspValid_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rspValid_r;
    assign rsp_data  = acc_r;
    assign rsp_id    = id_r;
    assign sh_in     = shIn_r;
    assign sh_amt    = shAmt_r;
    assign sh_left   = shLeft_r;
    assign sh_arith  = shArith_r;
    assign busy      = busy_r;
endmodule

// File: tb/tb_shift_unit_sequencer.sv
// Directed bench for shift_unit_sequencer with a behavioural shifter on the sh_* port.
module tb_shift_unit_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_data, req0_amt, req1_data, req1_amt;
    logic [2:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_data, sh_in, sh_amt, sh_out;
    logic        sh_left, sh_arith, busy;

    int checks = 0;
    int errors = 0;

    shift_unit_sequencer #(.FIRST_GRANT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_amt(req0_amt), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_amt(req1_amt), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .sh_in(sh_in), .sh_amt(sh_amt), .sh_left(sh_left), .sh_arith(sh_arith),
        .sh_out(sh_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the external combinational shifter.
    always_comb begin
        if (sh_left) sh_out = sh_in << sh_amt;
        else if (sh_arith) sh_out = $unsigned($signed(sh_in) >>> sh_amt);
        else sh_out = sh_in >> sh_amt;
    end

    typedef struct {
        logic        id;
        logic [2:0]  op;
        logic [31:0] data;
        logic [31:0] amt;
        logic [31:0] expData;
        logic [31:0] expAmt1;
        logic        expLeft1;
        logic [31:0] expAmt2;
        int          expLat;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic driveReq(input logic id, input logic [2:0] op, input logic [31:0] d, input logic [31:0] a);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_data = d; req1_amt = a;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_data = d; req0_amt = a;
        end
    endtask

    task automatic clearReqs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic runVec(input int idx, input vec_t v);
        int waitCnt;
        int lat;
        logic [31:0] amt2Seen;
        driveReq(v.id, v.op, v.data, v.amt);
        #1;
        waitCnt = 0;
        while (!(v.id ? req1_ready : req0_ready) && waitCnt < 10) begin
            nextCycle();
            waitCnt++;
        end
        chk($sformatf("v%0d_ready", idx), {31'd0, v.id ? req1_ready : req0_ready}, 32'd1);
        nextCycle();
        clearReqs();
        chk($sformatf("v%0d_p1_amt", idx), sh_amt, v.expAmt1);
        chk($sformatf("v%0d_p1_left", idx), {31'd0, sh_left}, {31'd0, v.expLeft1});
        chk($sformatf("v%0d_p1_in", idx), sh_in, v.data);
        chk($sformatf("v%0d_busy", idx), {31'd0, busy}, 32'd1);
        lat = 1;
        amt2Seen = 32'd0;
        while (!rsp_valid && lat < 6) begin
            nextCycle();
            lat++;
            if (lat == 2 && !rsp_valid) amt2Seen = sh_amt;
        end
        chk($sformatf("v%0d_latency", idx), lat, v.expLat);
        chk($sformatf("v%0d_p2_amt", idx), amt2Seen, v.expAmt2);
        chk($sformatf("v%0d_data", idx), rsp_data, v.expData);
        chk($sformatf("v%0d_id", idx), {31'd0, rsp_id}, {31'd0, v.id});
        chk($sformatf("v%0d_done_sh_idle", idx), sh_amt | sh_in, 32'd0);
        rsp_ready = 1'b1;
        nextCycle();
        rsp_ready = 1'b0;
        chk($sformatf("v%0d_rsp_drop", idx), {30'd0, rsp_valid, busy}, 32'd0);
    endtask

    initial begin
        int grants[$];
        int ids[$];
        logic [31:0] rdata[$];
        int bothReady;
        int waitCnt;
        logic sawRsp;

        vecs[0]  = '{1'b0, 3'd0, 32'hE2641233, 32'd4,    32'h26412330, 32'd4,  1'b1, 32'd0,  2};
        vecs[1]  = '{1'b1, 3'd2, 32'hE2641233, 32'd4,    32'hFE264123, 32'd4,  1'b0, 32'd0,  2};
        vecs[2]  = '{1'b1, 3'd1, 32'hE2641233, 32'd1256, 32'h00000000, 32'd0,  1'b0, 32'd0,  2};
        vecs[3]  = '{1'b0, 3'd2, 32'hE2641233, 32'd1256, 32'hFFFFFFFF, 32'd31, 1'b0, 32'd0,  2};
        vecs[4]  = '{1'b0, 3'd3, 32'hE2641233, 32'd4,    32'h2641233E, 32'd4,  1'b1, 32'd28, 3};
        vecs[5]  = '{1'b0, 3'd4, 32'hE2641233, 32'd36,   32'h3E264123, 32'd4,  1'b0, 32'd28, 3};
        vecs[6]  = '{1'b0, 3'd4, 32'hE2641233, 32'd32,   32'hE2641233, 32'd0,  1'b0, 32'd0,  2};
        vecs[7]  = '{1'b1, 3'd5, 32'h12345678, 32'd7,    32'h12345678, 32'd0,  1'b0, 32'd0,  2};
        vecs[8]  = '{1'b1, 3'd0, 32'hA5A5A5A5, 32'd0,    32'hA5A5A5A5, 32'd0,  1'b1, 32'd0,  2};
        vecs[9]  = '{1'b0, 3'd0, 32'hFFFFFFFF, 32'd32,   32'h00000000, 32'd0,  1'b1, 32'd0,  2};
        vecs[10] = '{1'b1, 3'd3, 32'h80000001, 32'd1,    32'h00000003, 32'd1,  1'b1, 32'd31, 3};
        vecs[11] = '{1'b0, 3'd1, 32'h80000000, 32'd31,   32'h00000001, 32'd31, 1'b0, 32'd0,  2};

        rst_n = 1'b0;
        rsp_ready = 1'b0;
        clearReqs();
        req0_data = 32'd0; req0_amt = 32'd0; req0_op = 3'd0;
        req1_data = 32'd0; req1_amt = 32'd0; req1_op = 3'd0;
        #12;
        chk("reset_rsp", {30'd0, rsp_valid, rsp_id}, 32'd0);
        chk("reset_data", rsp_data, 32'd0);
        chk("reset_sh", sh_in | sh_amt | {30'd0, sh_left, sh_arith}, 32'd0);
        chk("reset_busy_ready", {29'd0, busy, req0_ready, req1_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();

        // Both requesters valid from reset: grants must alternate starting at 0.
        driveReq(1'b0, 3'd0, 32'h0000000F, 32'd0);
        driveReq(1'b1, 3'd0, 32'h000000F0, 32'd0);
        rsp_ready = 1'b1;
        #1;
        bothReady = 0;
        for (int t = 0; t < 12; t++) begin
            if (req0_ready && req1_ready) bothReady++;
            if (req0_ready) grants.push_back(0);
            else if (req1_ready) grants.push_back(1);
            if (rsp_valid) begin
                ids.push_back(int'(rsp_id));
                rdata.push_back(rsp_data);
            end
            nextCycle();
        end
        clearReqs();
        nextCycle();
        rsp_ready = 1'b0;
        chk("rr_both_ready", bothReady, 32'd0);
        chk("rr_grant_count", grants.size(), 32'd4);
        chk("rr_rsp_count", ids.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) chk($sformatf("rr_grant%0d", i), grants[i], i % 2);
            if (i < ids.size()) begin
                chk($sformatf("rr_id%0d", i), ids[i], i % 2);
                chk($sformatf("rr_data%0d", i), rdata[i], (i % 2 == 0) ? 32'h0000000F : 32'h000000F0);
            end
        end

        for (int i = 0; i < 12; i++) runVec(i, vecs[i]);

        // Backpressure: response held for 5 cycles while both requesters wait.
        driveReq(1'b0, 3'd0, 32'hE2641233, 32'd4);
        #1;
        waitCnt = 0;
        while (!req0_ready && waitCnt < 10) begin nextCycle(); waitCnt++; end
        chk("bp_accept", {31'd0, req0_ready}, 32'd1);
        nextCycle();
        driveReq(1'b1, 3'd1, 32'h00000001, 32'd1);
        waitCnt = 0;
        while (!rsp_valid && waitCnt < 6) begin nextCycle(); waitCnt++; end
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_hold%0d", c), {rsp_valid, rsp_id, rsp_data[29:0]}, {1'b1, 1'b0, 30'h26412330});
            chk($sformatf("bp_gate%0d", c), {29'd0, req0_ready, req1_ready, busy}, 32'd1);
            chk($sformatf("bp_word%0d", c), rsp_data, 32'h26412330);
            nextCycle();
        end
        clearReqs();
        rsp_ready = 1'b1;
        nextCycle();
        rsp_ready = 1'b0;
        chk("bp_release", {31'd0, rsp_valid}, 32'd0);

        // Reset during PASS2 of a req0 rotate: no response, priority back to requester 0.
        driveReq(1'b0, 3'd3, 32'hE2641233, 32'd4);
        #1;
        chk("mr_accept", {31'd0, req0_ready}, 32'd1);
        nextCycle();
        clearReqs();
        nextCycle();
        chk("mr_in_pass2", sh_amt, 32'd28);
        rst_n = 1'b0;
        #1;
        chk("mr_async", {29'd0, rsp_valid, busy, sh_left}, 32'd0);
        chk("mr_async_sh", sh_amt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sawRsp = 1'b0;
        for (int c = 0; c < 5; c++) begin
            nextCycle();
            if (rsp_valid) sawRsp = 1'b1;
        end
        chk("mr_no_rsp", {31'd0, sawRsp}, 32'd0);
        driveReq(1'b1, 3'd0, 32'h00000011, 32'd0);
        driveReq(1'b0, 3'd0, 32'h00000022, 32'd0);
        #1;
        chk("mr_regrant", {30'd0, req0_ready, req1_ready}, 32'd2);
        nextCycle();
        clearReqs();
        waitCnt = 0;
        while (!rsp_valid && waitCnt < 6) begin nextCycle(); waitCnt++; end
        chk("mr_rsp", {rsp_valid, rsp_id, 30'd0}, {1'b1, 1'b0, 30'd0});
        chk("mr_rsp_data", rsp_data, 32'h00000022);
        rsp_ready = 1'b1;
        nextCycle();
        rsp_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
